// File: rtl/branch_unit_pkg.sv
// Shared core definitions for the branch unit: funct3 encodings, BHT counter
// reset value and small helpers for counter update and decode.
package branch_unit_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_ILL2 = 3'b010,
    BR_ILL3 = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct_e;

  localparam logic [1:0] BHT_CNT_RESET = 2'b01;

  function automatic logic [1:0] sat_cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return nxt;
  endfunction

  function automatic logic is_illegal_funct3(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Branch unit request/response bundle; the core drives it as master, the
// branch unit consumes it as slave.
interface branch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] lookup_pc_i;
  logic            pred_taken_o;
  logic            valid_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] imm_i;
  logic            pred_i;
  logic            flush_i;
  logic            res_valid_o;
  logic            taken_o;
  logic [XLEN-1:0] redirect_o;
  logic            mispredict_o;
  logic            misaligned_o;
  logic            illegal_o;

  modport master (
    output lookup_pc_i, valid_i, funct3_i, rs1_i, rs2_i, pc_i, imm_i, pred_i, flush_i,
    input  pred_taken_o, res_valid_o, taken_o, redirect_o, mispredict_o, misaligned_o,
           illegal_o
  );

  modport slave (
    input  lookup_pc_i, valid_i, funct3_i, rs1_i, rs2_i, pc_i, imm_i, pred_i, flush_i,
    output pred_taken_o, res_valid_o, taken_o, redirect_o, mispredict_o, misaligned_o,
           illegal_o
  );
endinterface

// File: rtl/branch_unit_cmp.sv
// Combinational XLEN-bit comparator: equality, signed and unsigned less-than.
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            eq_o,
  output logic            lt_s_o,
  output logic            lt_u_o
);

  assign eq_o   = (a_i == b_i);
  assign lt_s_o = ($signed(a_i) < $signed(b_i));
  assign lt_u_o = (a_i < b_i);

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: one register stage of compare/target results, then
// direction/redirect decode, plus a direct-mapped 2-bit-counter BHT.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  branch_unit_if.slave   bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic            eq_s;
  logic            lt_s_s;
  logic            lt_u_s;
  logic [XLEN-1:0] target_d;
  logic [XLEN-1:0] pc4_d;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] lookup_idx_s;

  logic             valid_q;
  logic [2:0]       funct3_q;
  logic             eq_q;
  logic             lt_s_q;
  logic             lt_u_q;
  logic             pred_q;
  logic [XLEN-1:0]  target_q;
  logic [XLEN-1:0]  pc4_q;
  logic [IDX_W-1:0] idx_q;

  logic [1:0]       bht_q [BHT_DEPTH];

  logic             res_valid_s;
  logic             taken_s;
  logic             illegal_s;
  logic             misaligned_s;
  logic             mispredict_s;
  logic [XLEN-1:0]  redirect_s;
  logic             bht_we_s;
  logic             unused_lookup_bits;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .a_i    (bus.rs1_i),
    .b_i    (bus.rs2_i),
    .eq_o   (eq_s),
    .lt_s_o (lt_s_s),
    .lt_u_o (lt_u_s)
  );

  assign target_d     = bus.pc_i + bus.imm_i;
  assign pc4_d        = bus.pc_i + {{(XLEN-3){1'b0}}, 3'b100};
  assign idx_d        = bus.pc_i[IDX_W+1:2];
  assign lookup_idx_s = bus.lookup_pc_i[IDX_W+1:2];
  assign unused_lookup_bits = ^{bus.lookup_pc_i[XLEN-1:IDX_W+2], bus.lookup_pc_i[1:0]};

  // Stage-1 capture of compare results and both candidate next PCs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      funct3_q <= 3'b000;
      eq_q     <= 1'b0;
      lt_s_q   <= 1'b0;
      lt_u_q   <= 1'b0;
      pred_q   <= 1'b0;
      target_q <= {XLEN{1'b0}};
      pc4_q    <= {XLEN{1'b0}};
      idx_q    <= {IDX_W{1'b0}};
    end else begin
      valid_q <= bus.valid_i;
      if (bus.valid_i) begin
        funct3_q <= bus.funct3_i;
        eq_q     <= eq_s;
        lt_s_q   <= lt_s_s;
        lt_u_q   <= lt_u_s;
        pred_q   <= bus.pred_i;
        target_q <= target_d;
        pc4_q    <= pc4_d;
        idx_q    <= idx_d;
      end else begin
        funct3_q <= funct3_q;
        eq_q     <= eq_q;
        lt_s_q   <= lt_s_q;
        lt_u_q   <= lt_u_q;
        pred_q   <= pred_q;
        target_q <= target_q;
        pc4_q    <= pc4_q;
        idx_q    <= idx_q;
      end
    end
  end

  // Resolve direction and next PC; every field is held at zero unless the result is reported.
  always_comb begin
    res_valid_s  = valid_q & ~bus.flush_i;
    taken_s      = 1'b0;
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    mispredict_s = 1'b0;
    redirect_s   = {XLEN{1'b0}};
    if (res_valid_s) begin
      case (br_funct_e'(funct3_q))
        BR_BEQ:  taken_s = eq_q;
        BR_BNE:  taken_s = ~eq_q;
        BR_BLT:  taken_s = lt_s_q;
        BR_BGE:  taken_s = ~lt_s_q;
        BR_BLTU: taken_s = lt_u_q;
        BR_BGEU: taken_s = ~lt_u_q;
        default: taken_s = 1'b0;
      endcase
      illegal_s    = is_illegal_funct3(funct3_q);
      misaligned_s = taken_s & (target_q[1:0] != 2'b00);
      mispredict_s = ~illegal_s & ~misaligned_s & (taken_s ^ pred_q);
      redirect_s   = taken_s ? target_q : pc4_q;
    end else begin
      taken_s = 1'b0;
    end
  end

  assign bht_we_s = res_valid_s & ~illegal_s;

  // Counter table: reset to weakly not-taken, trained when a legal result retires.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= BHT_CNT_RESET;
      end
    end else if (bht_we_s) begin
      bht_q[idx_q] <= sat_cnt_next(bht_q[idx_q], taken_s);
    end else begin
      bht_q[idx_q] <= bht_q[idx_q];
    end
  end

  assign bus.pred_taken_o = bht_q[lookup_idx_s][1];
  assign bus.res_valid_o  = res_valid_s;
  assign bus.taken_o      = taken_s;
  assign bus.illegal_o    = illegal_s;
  assign bus.misaligned_o = misaligned_s;
  assign bus.mispredict_o = mispredict_s;
  assign bus.redirect_o   = redirect_s;

endmodule
